// File: rtl/uart_tx_feeder_pkg.sv
// Shared encodings for the UART transmit feeder: FSM states and byte width.
package uart_tx_feeder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Byte FIFO with registered count/flags and sticky overflow; head is read combinationally.
// Writes while full are dropped unless a pop happens in the same cycle.
module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              clr_ovf_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              ovf_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              do_pop, do_wr, drop;

  always_comb begin
    do_pop   = pop_i && !empty_q;
    // A pop in the same cycle frees the slot, so a write while full still lands.
    do_wr    = wr_i && (!full_q || do_pop);
    drop     = wr_i && full_q && !do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers capture bytes and hands them to the UART one at a time, paced by TiP.
// A byte written at edge N is requested after edge N+1; one idle cycle separates frames.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] I_DATA,
  input  logic              I_WR,
  input  logic              I_CLR_OVF,
  input  logic              TiP,
  output logic [BYTE_W-1:0] O_DATA,
  output logic              send_data,
  output logic              O_FULL,
  output logic              O_EMPTY,
  output logic [AW:0]       O_COUNT,
  output logic              O_OVF
);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              send_q, send_d;
  logic              pop;
  logic [BYTE_W-1:0] head;
  logic              fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (I_WR),
    .wdata_i   (I_DATA),
    .clr_ovf_i (I_CLR_OVF),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (O_FULL),
    .empty_o   (fifo_empty),
    .count_o   (O_COUNT),
    .ovf_o     (O_OVF)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // TiP high here means the UART is busy for someone else; wait it out.
        if (!fifo_empty && !TiP) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (TiP) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!TiP) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    send_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      send_q  <= send_d;
    end
  end

  assign O_DATA    = data_q;
  assign send_data = send_q;
  assign O_EMPTY   = fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: UART model with scoreboard, table-driven overflow vectors, corner sequences.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int HOLD  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    I_DATA = 8'h00;
  logic          I_WR = 1'b0;
  logic          I_CLR_OVF = 1'b0;
  logic          TiP = 1'b0;
  logic [7:0]    O_DATA;
  logic          send_data;
  logic          O_FULL;
  logic          O_EMPTY;
  logic [AW:0]   O_COUNT;
  logic          O_OVF;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .I_DATA    (I_DATA),
    .I_WR      (I_WR),
    .I_CLR_OVF (I_CLR_OVF),
    .TiP       (TiP),
    .O_DATA    (O_DATA),
    .send_data (send_data),
    .O_FULL    (O_FULL),
    .O_EMPTY   (O_EMPTY),
    .O_COUNT   (O_COUNT),
    .O_OVF     (O_OVF)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] sb[$];

  bit         auto_mode = 1'b1;
  bit         tip_force = 1'b0;
  bit         check_gap = 1'b0;
  bit         have_prev = 1'b0;
  int         phase = 0;
  int         cnt   = 0;
  int         gap   = 0;
  logic [7:0] cur;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic       acc;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (!(sb.size() == 0 && phase == 0 && O_EMPTY === 1'b1 && send_data === 1'b0) && n < max) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(n < max), 32'd1);
  endtask

  // UART model: raises TiP two cycles after seeing send_data, holds it HOLD cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        phase = 0;
        TiP = auto_mode ? 1'b0 : tip_force;
      end else if (!auto_mode) begin
        TiP = tip_force;
      end else begin
        case (phase)
          0: begin
            TiP = 1'b0;
            if (send_data === 1'b1) begin
              cur = O_DATA;
              if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL rx_order: got byte %0h with nothing expected", cur);
              end else begin
                check("rx_order", 32'(cur), 32'(sb.pop_front()));
              end
              if (check_gap && have_prev) check("idle_gap", gap, 1);
              have_prev = 1'b1;
              phase = 1;
              cnt = 0;
            end else begin
              gap++;
            end
          end
          1: begin
            check("send_held", 32'(send_data), 32'd1);
            check("data_held_send", 32'(O_DATA), 32'(cur));
            cnt++;
            if (cnt == 2) begin
              TiP = 1'b1;
              phase = 2;
              cnt = 0;
            end
          end
          default: begin
            check("send_drop", 32'(send_data), 32'd0);
            check("data_held_busy", 32'(O_DATA), 32'(cur));
            cnt++;
            if (cnt == HOLD) begin
              TiP = 1'b0;
              phase = 0;
              gap = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int peak;
    int n;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 8'(8'h80 + i), 1'b0, 1'b1, i + 1, (i == 15), 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h90, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 8'h91, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0};

    #1 rst = 1'b0;
    repeat (3) tick();
    check("rst_count", 32'(O_COUNT), 32'd0);
    check("rst_empty", 32'(O_EMPTY), 32'd1);
    check("rst_full", 32'(O_FULL), 32'd0);
    check("rst_send", 32'(send_data), 32'd0);
    check("rst_data", 32'(O_DATA), 32'd0);
    check("rst_ovf", 32'(O_OVF), 32'd0);
    rst = 1'b1;
    tick();

    // Single byte latency
    I_WR = 1'b1; I_DATA = 8'h41; sb.push_back(8'h41);
    tick();
    I_WR = 1'b0;
    check("single_empty_n", 32'(O_EMPTY), 32'd0);
    check("single_send_n", 32'(send_data), 32'd0);
    check("single_count_n", 32'(O_COUNT), 32'd1);
    tick();
    check("single_send_n1", 32'(send_data), 32'd1);
    check("single_data_n1", 32'(O_DATA), 32'h41);
    check("single_empty_n1", 32'(O_EMPTY), 32'd1);
    wait_idle("single", 200);

    // Burst ordering and inter-frame gap
    check_gap = 1'b1; have_prev = 1'b0; peak = 0;
    for (int i = 0; i < 10; i++) begin
      I_WR = 1'b1; I_DATA = 8'(i); sb.push_back(8'(i));
      tick();
      if (int'(O_COUNT) > peak) peak = int'(O_COUNT);
    end
    I_WR = 1'b0;
    repeat (3) begin
      tick();
      if (int'(O_COUNT) > peak) peak = int'(O_COUNT);
    end
    check("burst_peak", peak, 9);
    wait_idle("burst", 1000);
    check_gap = 1'b0;

    // Overflow vectors with TiP held high so nothing pops
    auto_mode = 1'b0; tip_force = 1'b1;
    for (int i = 0; i < 22; i++) begin
      I_WR = vecs[i].wr; I_DATA = vecs[i].d; I_CLR_OVF = vecs[i].clr;
      if (vecs[i].acc) sb.push_back(vecs[i].d);
      tick();
      check($sformatf("vec%0d_count", i), 32'(O_COUNT), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_full", i), 32'(O_FULL), 32'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 32'(O_EMPTY), 32'(vecs[i].empty));
      check($sformatf("vec%0d_ovf", i), 32'(O_OVF), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_send", i), 32'(send_data), 32'd0);
    end
    I_WR = 1'b0; I_CLR_OVF = 1'b0;

    // Write while full in the same cycle as the pop
    auto_mode = 1'b1;
    I_WR = 1'b1; I_DATA = 8'hAA; sb.push_back(8'hAA);
    tick();
    I_WR = 1'b0;
    check("fullpop_count", 32'(O_COUNT), 32'd16);
    check("fullpop_full", 32'(O_FULL), 32'd1);
    check("fullpop_ovf", 32'(O_OVF), 32'd0);
    check("fullpop_send", 32'(send_data), 32'd1);
    wait_idle("fullpop", 2000);

    // Reset mid-SEND with 5 bytes buffered
    auto_mode = 1'b0; tip_force = 1'b0;
    for (int i = 0; i < 6; i++) begin
      I_WR = 1'b1; I_DATA = 8'(8'h60 + i);
      tick();
    end
    I_WR = 1'b0;
    check("midsend_count", 32'(O_COUNT), 32'd5);
    check("midsend_send", 32'(send_data), 32'd1);
    check("midsend_data", 32'(O_DATA), 32'h60);
    rst = 1'b0;
    #1;
    check("arst_send", 32'(send_data), 32'd0);
    check("arst_count", 32'(O_COUNT), 32'd0);
    check("arst_empty", 32'(O_EMPTY), 32'd1);
    check("arst_data", 32'(O_DATA), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("postrst_count", 32'(O_COUNT), 32'd0);
    check("postrst_empty", 32'(O_EMPTY), 32'd1);
    check("postrst_send", 32'(send_data), 32'd0);
    check("postrst_data", 32'(O_DATA), 32'd0);
    tick();
    check("postrst_idle", 32'(send_data), 32'd0);
    sb.delete();
    auto_mode = 1'b1;

    // Pointer wrap: 40 bytes in groups of 5 while draining
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 5; k++) begin
        I_WR = 1'b1; I_DATA = 8'(8'h10 + g * 5 + k); sb.push_back(8'(8'h10 + g * 5 + k));
        tick();
      end
      I_WR = 1'b0;
      n = 0;
      while (int'(O_COUNT) > 2 && n < 500) begin
        tick();
        n++;
      end
      check("wrap_pace", 32'(n < 500), 32'd1);
    end
    wait_idle("wrap", 2000);
    check("wrap_ovf", 32'(O_OVF), 32'd0);
    check("wrap_empty", 32'(O_EMPTY), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffers bytes from the USB3300 sniffer capture path and feeds the UART transmitter one byte at a time.
- Drives the UART's I_DATA/send_data inputs and paces itself on the UART's TiP (transmission-in-progress) output, so bursts faster than the baud rate are absorbed without loss until the buffer fills.
- Sits directly upstream of UART in the sniffer top level.

Parameters:
- DEPTH, 16, FIFO depth in bytes; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), FIFO address width; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- I_DATA  input  8  byte from the capture path
- I_WR  input  1  write strobe; one byte accepted per cycle while high
- I_CLR_OVF  input  1  synchronous clear of O_OVF
- TiP  input  1  UART transmission-in-progress flag
- O_DATA  output  8  byte to UART I_DATA
- send_data  output  1  transmit request to UART
- O_FULL  output  1  FIFO holds DEPTH bytes
- O_EMPTY  output  1  FIFO holds 0 bytes
- O_COUNT  output  AW+1  current FIFO occupancy
- O_OVF  output  1  sticky overflow flag

Behaviour:
- Reset (rst=0, asynchronous) clears pointers, count, FSM and outputs:
  - O_DATA=0, send_data=0, O_FULL=0, O_EMPTY=1, O_COUNT=0, O_OVF=0.
  - Reset mid-transmission discards all buffered bytes and drops send_data at once. Effects on the UART are outside this block.
- Write side:
  - I_WR=1 and not full: I_DATA stored at wr_ptr, wr_ptr increments and wraps modulo DEPTH.
  - I_WR=1 while full with no pop in the same cycle: byte dropped, O_OVF set. O_OVF stays set until I_CLR_OVF=1.
  - If I_CLR_OVF and a new overflow occur in the same cycle, set wins.
  - Write while full in the same cycle as a pop: write accepted, count unchanged.
- Flags and count:
  - O_COUNT updates on the edge: +1 on write only, -1 on pop only, unchanged on both or neither.
  - O_FULL is (count==DEPTH) and O_EMPTY is (count==0), both registered from the next count.
- Transmit FSM: states IDLE, SEND, BUSY.
  - IDLE, FIFO not empty: pop head into O_DATA register, go SEND. send_data goes high on the same edge.
  - SEND: send_data=1, O_DATA held. On TiP=1, deassert send_data and go BUSY.
  - BUSY: send_data=0, O_DATA held. On TiP=0, go IDLE.
- Latency:
  - A byte written into an empty FIFO at edge N is visible (O_EMPTY=0) after N.
  - It is popped with send_data=1 after edge N+1.
  - Back-to-back bytes: the next pop occurs on the edge after the IDLE cycle that follows TiP falling, so there is 1 idle cycle between UART frames.
- TiP=1 seen in IDLE (UART busy from an external source): FSM stays in IDLE until TiP=0 before popping.
- O_DATA never changes while send_data=1 or while the FSM is in BUSY.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, SEND=2'd1, BUSY=2'd2) and the byte width constant (8).
- Sub-module sync_fifo:
  - Parameterised by DEPTH.
  - Owns storage, pointers, count, full/empty and overflow.
  - Exposes a pop strobe and head data.
- uart_tx_feeder contains the FSM and instantiates sync_fifo.

Test Plan:
- Reset: rst=0 for 3 cycles mid-SEND with 5 bytes buffered, then rst=1 -> O_COUNT=0, O_EMPTY=1, send_data=0, O_DATA=0, FSM IDLE.
- Single byte: write 8'h41 once, UART model raises TiP 2 cycles after send_data and holds it 20 cycles -> send_data high exactly from edge N+1 until TiP rises, O_DATA=8'h41 throughout, O_EMPTY=1 after the pop.
- Burst ordering: write 8'h00..8'h09 on consecutive cycles -> UART model receives 00..09 in order, 1 idle cycle between frames, O_COUNT peaks at 9 (one already popped).
- Overflow, DEPTH=16, TiP held 1: write 17 bytes -> O_FULL=1 after 16 (one may be popped, so expect overflow at write 18 if popped first). O_OVF=1 after the first dropped write and stays set. I_CLR_OVF pulse -> O_OVF=0.
- Full plus simultaneous pop: FIFO full, write 8'hAA in the same cycle SEND pops the head -> write accepted, O_COUNT stays 16, O_OVF stays 0, 8'hAA transmitted last.
- Pointer wrap: 40 bytes 8'h10..8'h37 written in groups of 5 while draining -> all received in order, O_OVF=0, O_EMPTY=1 at end.
